// File: rtl/sum_sequence_matcher_if.sv
// Player-sum bus between the game controller/adder side (master) and the
// sum_sequence_matcher (slave).
//   Clear, Target_Load, Target_Data, Start, Valid, S : master -> slave
//   Allow, Step, Timer, Match, Win, Lose, Timeout    : slave -> master
interface sum_sequence_matcher_if #(
  parameter int unsigned TW = 4
);
  logic          Clear;
  logic          Target_Load;
  logic [3:0]    Target_Data;
  logic          Start;
  logic          Valid;
  logic [3:0]    S;
  logic          Allow;
  logic [2:0]    Step;
  logic [TW-1:0] Timer;
  logic          Match;
  logic          Win;
  logic          Lose;
  logic          Timeout;

  modport master (
    output Clear, Target_Load, Target_Data, Start, Valid, S,
    input  Allow, Step, Timer, Match, Win, Lose, Timeout
  );

  modport slave (
    input  Clear, Target_Load, Target_Data, Start, Valid, S,
    output Allow, Step, Timer, Match, Win, Lose, Timeout
  );
endinterface

// File: rtl/sum_sequence_matcher.sv
// Consumer end of the player-sum path: holds a target sequence of 4-bit sums,
// enables the adder (Allow) while a round is running, checks each confirmed
// sum against the next target entry and enforces a per-step time limit.
// Ports:
//   Clk   : system clock, rising edge
//   Reset : asynchronous, active-high reset
//   bus   : sum_sequence_matcher_if slave (load/start/valid/S in; status out)
module sum_sequence_matcher #(
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TW      = 4
) (
  input logic                  Clk,
  input logic                  Reset,
  sum_sequence_matcher_if.slave bus
);

  localparam int unsigned PW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int unsigned CW = $clog2(SEQ_LEN + 1);
  localparam logic [TW-1:0] TimerInit = TW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWait, StWin, StLose} state_e;

  state_e        state_q, state_d;
  logic [3:0]    mem_q [SEQ_LEN];
  logic          mem_we;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    step_q, step_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          allow_q, allow_d;
  logic          match_q, match_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    timer_d   = timer_q;
    allow_d   = allow_q;
    match_d   = 1'b0;
    win_d     = win_q;
    lose_d    = lose_q;
    timeout_d = timeout_q;

    if (bus.Clear) begin
      // Discarding the sequence only needs the count cleared; slots are rewritten on reload.
      state_d   = StIdle;
      wr_ptr_d  = '0;
      cnt_d     = '0;
      step_d    = '0;
      timer_d   = '0;
      allow_d   = 1'b0;
      win_d     = 1'b0;
      lose_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.Target_Load) begin
            mem_we   = 1'b1;
            wr_ptr_d = (wr_ptr_q == PW'(SEQ_LEN - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (cnt_q != CW'(SEQ_LEN)) cnt_d = cnt_q + CW'(1);
          end
          // Start sees the count before any same-cycle load.
          if (bus.Start && cnt_q == CW'(SEQ_LEN)) begin
            state_d   = StWait;
            step_d    = '0;
            timer_d   = TimerInit;
            allow_d   = 1'b1;
            win_d     = 1'b0;
            lose_d    = 1'b0;
            timeout_d = 1'b0;
          end
        end
        StWait: begin
          // Valid wins over expiry, so an entry in the final cycle still counts.
          if (bus.Valid) begin
            if (bus.S == mem_q[step_q[PW-1:0]]) begin
              match_d = 1'b1;
              timer_d = TimerInit;
              if (step_q == 3'(SEQ_LEN - 1)) begin
                state_d = StWin;
                allow_d = 1'b0;
                win_d   = 1'b1;
              end else begin
                step_d = step_q + 3'd1;
              end
            end else begin
              state_d   = StLose;
              allow_d   = 1'b0;
              lose_d    = 1'b1;
              timeout_d = 1'b0;
            end
          end else if (timer_q == '0) begin
            state_d   = StLose;
            allow_d   = 1'b0;
            lose_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        StWin, StLose: begin
          // Only reachable with a full sequence, so no count check is needed.
          if (bus.Start) begin
            state_d   = StWait;
            step_d    = '0;
            timer_d   = TimerInit;
            allow_d   = 1'b1;
            win_d     = 1'b0;
            lose_d    = 1'b0;
            timeout_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      step_q    <= '0;
      timer_q   <= '0;
      allow_q   <= 1'b0;
      match_q   <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      timer_q   <= timer_d;
      allow_q   <= allow_d;
      match_q   <= match_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      timeout_q <= timeout_d;
    end
  end

  // Target storage needs no reset: validity is tracked by cnt_q.
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= bus.Target_Data;
  end

  assign bus.Allow   = allow_q;
  assign bus.Step    = step_q;
  assign bus.Timer   = timer_q;
  assign bus.Match   = match_q;
  assign bus.Win     = win_q;
  assign bus.Lose    = lose_q;
  assign bus.Timeout = timeout_q;

endmodule

// File: tb/tb_sum_sequence_matcher.sv
// Directed, table-driven bench for sum_sequence_matcher (SEQ_LEN=4, TIMEOUT=15).
// Outputs are compared as one packed word {Allow,Step,Timer,Match,Win,Lose,Timeout}.
module tb_sum_sequence_matcher;

  logic Clk;
  logic Reset;

  sum_sequence_matcher_if #(.TW(4)) bus ();

  sum_sequence_matcher #(
    .SEQ_LEN(4),
    .TIMEOUT(15),
    .TW     (4)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       clear;
    logic       load;
    logic [3:0] data;
    logic       start;
    logic       valid;
    logic [3:0] s;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [64];
  int   nvec;
  int   checks;
  int   errors;

  function automatic logic [11:0] pk(input logic allow, input logic [2:0] step,
                                     input logic [3:0] timer, input logic match,
                                     input logic win, input logic lose, input logic to);
    return {allow, step, timer, match, win, lose, to};
  endfunction

  function automatic logic [11:0] outs();
    return {bus.Allow, bus.Step, bus.Timer, bus.Match, bus.Win, bus.Lose, bus.Timeout};
  endfunction

  task automatic add(input logic clear, input logic load, input logic [3:0] data,
                     input logic start, input logic valid, input logic [3:0] s,
                     input logic [11:0] exp);
    vecs[nvec].clear = clear;
    vecs[nvec].load  = load;
    vecs[nvec].data  = data;
    vecs[nvec].start = start;
    vecs[nvec].valid = valid;
    vecs[nvec].s     = s;
    vecs[nvec].exp   = exp;
    nvec++;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {A,Step,Tmr,M,W,L,T}=%b_%0d_%0d_%b%b%b%b want %b_%0d_%0d_%b%b%b%b",
               name, act[11], act[10:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[11], exp[10:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic clear, input logic load, input logic [3:0] data,
                       input logic start, input logic valid, input logic [3:0] s);
    bus.Clear       = clear;
    bus.Target_Load = load;
    bus.Target_Data = data;
    bus.Start       = start;
    bus.Valid       = valid;
    bus.S           = s;
  endtask

  // Take one rising edge and settle just past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  localparam logic [11:0] Z = 12'd0;

  initial begin
    checks = 0;
    errors = 0;
    nvec   = 0;
    drive(0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    #12;
    check("reset", outs(), Z);
    Reset = 1'b0;
    tick();
    check("idle_after_reset", outs(), Z);

    // Full win: load 3,7,0,15; entries on every second cycle.
    add(0, 1, 4'd3,  0, 0, 0, Z);
    add(0, 1, 4'd7,  0, 0, 0, Z);
    add(0, 1, 4'd0,  0, 0, 0, Z);
    add(0, 1, 4'd15, 0, 0, 0, Z);
    add(0, 0, 0, 1, 0, 0,     pk(1, 0, 15, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0,     pk(1, 0, 14, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd3,  pk(1, 1, 15, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0,     pk(1, 1, 14, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd7,  pk(1, 2, 15, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0,     pk(1, 2, 14, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd0,  pk(1, 3, 15, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0,     pk(1, 3, 14, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd15, pk(0, 3, 15, 1, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0,     pk(0, 3, 15, 0, 1, 0, 0));
    add(0, 1, 4'd9, 0, 0, 0,  pk(0, 3, 15, 0, 1, 0, 0));  // load ignored in WIN
    // Wrong entry: restart from WIN.
    add(0, 0, 0, 1, 0, 0,     pk(1, 0, 15, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd3,  pk(1, 1, 15, 1, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd8,  pk(0, 1, 15, 0, 0, 1, 0));
    add(0, 0, 0, 0, 1, 4'd7,  pk(0, 1, 15, 0, 0, 1, 0));  // Valid ignored in LOSE
    add(0, 0, 0, 1, 0, 0,     pk(1, 0, 15, 0, 0, 0, 0));
    add(0, 0, 0, 1, 1, 4'd3,  pk(1, 1, 15, 1, 0, 0, 0));  // Start ignored in WAIT
    // Clear beats Start/Valid; sequence discarded.
    add(1, 0, 0, 1, 1, 4'd7,  Z);
    add(0, 0, 0, 1, 0, 0,     Z);
    add(0, 1, 4'd1, 0, 0, 0,  Z);
    add(0, 1, 4'd2, 0, 0, 0,  Z);
    add(0, 1, 4'd3, 0, 0, 0,  Z);
    add(0, 0, 0, 1, 0, 0,     Z);                         // only 3 loaded
    add(0, 1, 4'd4, 1, 0, 0,  Z);                         // Start sees pre-load count
    add(0, 0, 0, 1, 0, 0,     pk(1, 0, 15, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd1,  pk(1, 1, 15, 1, 0, 0, 0));
    // Wrap: load 1..5 leaves 5,2,3,4.
    add(1, 0, 0, 0, 0, 0,     Z);
    add(0, 1, 4'd1, 0, 0, 0,  Z);
    add(0, 1, 4'd2, 0, 0, 0,  Z);
    add(0, 1, 4'd3, 0, 0, 0,  Z);
    add(0, 1, 4'd4, 0, 0, 0,  Z);
    add(0, 1, 4'd5, 0, 0, 0,  Z);
    add(0, 0, 0, 1, 0, 0,     pk(1, 0, 15, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd5,  pk(1, 1, 15, 1, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd2,  pk(1, 2, 15, 1, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd3,  pk(1, 3, 15, 1, 0, 0, 0));
    add(0, 0, 0, 0, 1, 4'd4,  pk(0, 3, 15, 1, 1, 0, 0));

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].clear, vecs[i].load, vecs[i].data, vecs[i].start, vecs[i].valid,
            vecs[i].s);
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Timeout: Timer counts 15..0, then Lose+Timeout on the next cycle.
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("to_start", outs(), pk(1, 0, 15, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("to_cnt%0d", k), outs(), pk(1, 0, 4'(15 - k), 0, 0, 0, 0));
    end
    tick();
    check("to_lose", outs(), pk(0, 0, 0, 0, 0, 1, 1));
    tick();
    check("to_hold", outs(), pk(0, 0, 0, 0, 0, 1, 1));

    // Correct entry on the exact cycle Timer==0 still counts.
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("fc_start", outs(), pk(1, 0, 15, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 15; k++) tick();
    check("fc_zero", outs(), pk(1, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 1, 4'd5);
    tick();
    check("fc_match", outs(), pk(1, 1, 15, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("fc_next", outs(), pk(1, 1, 14, 0, 0, 0, 0));

    // Async reset mid-WAIT: outputs drop without a clock edge.
    #1;
    Reset = 1'b1;
    #1;
    check("async_reset", outs(), Z);
    #1;
    Reset = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("start_after_reset", outs(), Z);
    drive(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
